brent_kung_adder: RTL and testbench

BRENT_KUNG_ADDER -- requirements
Module: brent_kung_adder

---
 rtl/brent_kung_adder.sv | 148 ++++++++++++++
 tb/tb_brent_kung_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/brent_kung_adder.sv
// ----------------------------------------------------------------------------
// brent_kung_adder
// Registered unsigned adder whose carries come from a Brent-Kung
// parallel-prefix network. {cout,out} = a + b, with no carry-in.
//
// Parameters
//   WIDTH      operand/sum width, power of two from 2 to 64 (default 16)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   qualifies a/b in the current cycle
//   a, b       unsigned addends
//   out        registered sum modulo 2^WIDTH
//   cout       registered carry-out (bit WIDTH of a+b)
//   out_valid  high for one cycle when out/cout hold a new result
//
// Configuration
//   BRENT_KUNG_INREG_EN  when defined, a/b/in_valid are registered ahead of
//                        the prefix network and latency grows from 1 to 2.
// ----------------------------------------------------------------------------
module brent_kung_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             out_valid
);

   localparam int unsigned LEVELS = $clog2(WIDTH);
   localparam int unsigned IDX_W  = (LEVELS < 1) ? 1 : LEVELS;

   // Operands seen by the prefix network
   logic [WIDTH-1:0] opa_c;
   logic [WIDTH-1:0] opb_c;
   logic             op_vld_c;

`ifdef BRENT_KUNG_INREG_EN
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             vld_q, vld_d;

   // Input stage captures every cycle; validity travels alongside the data
   always_comb begin
      a_d   = a;
      b_d   = b;
      vld_d = in_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         vld_q <= vld_d;
      end
   end

   assign opa_c    = a_q;
   assign opb_c    = b_q;
   assign op_vld_c = vld_q;
`else
   assign opa_c    = a;
   assign opb_c    = b;
   assign op_vld_c = in_valid;
`endif

   // Prefix network signals
   logic [WIDTH-1:0] gen_c;
   logic [WIDTH-1:0] prop_c;
   logic [WIDTH-1:0] grp_g_c;
   logic [WIDTH-1:0] grp_p_c;
   logic [WIDTH-1:0] sum_c;
   logic             carry_c;

   // Brent-Kung prefix tree, updated in place.
   // Up-sweep: at level k, node i (i+1 a multiple of 2^(k+1)) absorbs the
   // 2^k-wide group ending at i-2^k, so power-of-two prefixes become complete.
   // Down-sweep: at level k, node i = 3*2^k-1 + j*2^(k+1) holds a 2^k-wide
   // group and its left neighbour i-2^k already holds a full prefix, so one
   // generate-only merge completes it. Only G is needed after the up-sweep.
   always_comb begin
      gen_c   = opa_c & opb_c;
      prop_c  = opa_c ^ opb_c;
      grp_g_c = gen_c;
      grp_p_c = prop_c;

      for (int k = 0; k < int'(LEVELS); k++) begin
         for (int i = (1 << (k + 1)) - 1; i < int'(WIDTH); i += (1 << (k + 1))) begin
            grp_g_c[IDX_W'(i)] = grp_g_c[IDX_W'(i)]
                               | (grp_p_c[IDX_W'(i)] & grp_g_c[IDX_W'(i - (1 << k))]);
            grp_p_c[IDX_W'(i)] = grp_p_c[IDX_W'(i)] & grp_p_c[IDX_W'(i - (1 << k))];
         end
      end

      for (int k = int'(LEVELS) - 2; k >= 0; k--) begin
         for (int i = (3 << k) - 1; i < int'(WIDTH); i += (1 << (k + 1))) begin
            grp_g_c[IDX_W'(i)] = grp_g_c[IDX_W'(i)]
                               | (grp_p_c[IDX_W'(i)] & grp_g_c[IDX_W'(i - (1 << k))]);
         end
      end
   end

   // grp_g_c[i] is now the carry out of bit i; bit 0 sees no carry-in
   assign sum_c   = prop_c ^ {grp_g_c[WIDTH-2:0], 1'b0};
   assign carry_c = grp_g_c[WIDTH-1];

   // Output register: hold result when idle, pulse valid on new data
   logic [WIDTH-1:0] out_q, out_d;
   logic             cout_q, cout_d;
   logic             out_valid_q, out_valid_d;

   always_comb begin
      out_d       = out_q;
      cout_d      = cout_q;
      out_valid_d = 1'b0;
      if (op_vld_c) begin
         out_d       = sum_c;
         cout_d      = carry_c;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign cout      = cout_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_brent_kung_adder.sv
// ----------------------------------------------------------------------------
// tb_brent_kung_adder
// Directed and randomized stimulus for brent_kung_adder (WIDTH=16) checked
// every cycle against an arithmetic reference with a latency queue.
// Latency expectation follows BRENT_KUNG_INREG_EN (2 when defined, else 1).
// ----------------------------------------------------------------------------
module tb_brent_kung_adder;

   localparam int unsigned W = 16;
`ifdef BRENT_KUNG_INREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] out;
   logic         cout;
   logic         out_valid;

   always #5 clk = ~clk;

   brent_kung_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out       (out),
      .cout      (cout),
      .out_valid (out_valid)
   );

   typedef struct packed {
      logic       v;
      logic [W:0] s;
   } ent_t;

   ent_t         pend[$];
   logic [W-1:0] m_out;
   logic         m_cout;
   logic         m_valid;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb);
      in_valid = v;
      a        = va;
      b        = vb;
   endtask

   // Advance the reference by one edge using the inputs currently applied,
   // then clock the DUT and compare all outputs.
   task automatic tick();
      ent_t       e;
      logic [W:0] s;
      if (rst) begin
         pend.delete();
         m_out   = '0;
         m_cout  = 1'b0;
         m_valid = 1'b0;
      end else begin
         s = (W+1)'(a) + (W+1)'(b);
         e.v = in_valid;
         e.s = s;
         pend.push_back(e);
         m_valid = 1'b0;
         if (pend.size() == LAT) begin
            e = pend.pop_front();
            if (e.v) begin
               m_valid = 1'b1;
               {m_cout, m_out} = e.s;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out",       64'(out),       64'(m_out));
      chk("cout",      64'(cout),      64'(m_cout));
   endtask

   // Feed idle cycles until a result issued LAT edges ago reaches the outputs
   task automatic flush_to_output();
      for (int n = 1; n < LAT; n++) begin
         drive(1'b0, W'($urandom), W'($urandom));
         tick();
      end
   endtask

   initial begin
      // Reset, with an operand pair that must be discarded
      rst = 1'b1;
      drive(1'b1, 16'd1, 16'd2);
      tick();
      tick();
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);

      // First result after reset, latency checked by the per-cycle model
      rst = 1'b0;
      drive(1'b1, 16'd1024, 16'd1023);
      tick();
      flush_to_output();
      chk("basic_out", 64'(out), 64'd2047);
      chk("basic_cout", 64'(cout), 64'd0);
      chk("basic_valid", 64'(out_valid), 64'd1);

      // Overflow wrap
      drive(1'b1, 16'hFFFF, 16'h0001);
      tick();
      flush_to_output();
      chk("wrap_out", 64'(out), 64'd0);
      chk("wrap_cout", 64'(cout), 64'd1);
      drive(1'b1, 16'hFFFF, 16'hFFFF);
      tick();
      flush_to_output();
      chk("max_out", 64'(out), 64'hFFFE);
      chk("max_cout", 64'(cout), 64'd1);

      // Hold during a three-cycle gap
      drive(1'b1, 16'd5, 16'd7);
      tick();
      flush_to_output();
      chk("gap_first_out", 64'(out), 64'd12);
      for (int n = 0; n < 3; n++) begin
         drive(1'b0, W'($urandom), W'($urandom));
         tick();
         chk("gap_out", 64'(out), 64'd12);
         chk("gap_cout", 64'(cout), 64'd0);
         chk("gap_valid", 64'(out_valid), 64'd0);
      end

      // Back-to-back sweep over 0..1023 on both operands
      for (int i = 0; i < 1024; i++) begin
         drive(1'b1, W'(i), W'(1023 - i));
         tick();
      end
      for (int i = 0; i < 1024; i++) begin
         drive(1'b1, W'(i), W'(i));
         tick();
      end

      // Randomized operands with sporadic idle cycles
      for (int n = 0; n < 2000; n++) begin
         drive(($urandom_range(3) != 0), W'($urandom), W'($urandom));
         tick();
      end

      // Reset while results are in flight; reset beats in_valid
      for (int n = 0; n < 4; n++) begin
         drive(1'b1, W'($urandom), W'($urandom));
         tick();
      end
      rst = 1'b1;
      drive(1'b1, 16'h1234, 16'h4321);
      tick();
      chk("midrst_out", 64'(out), 64'd0);
      chk("midrst_cout", 64'(cout), 64'd0);
      chk("midrst_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;
      for (int n = 0; n < LAT + 2; n++) begin
         drive(1'b0, W'($urandom), W'($urandom));
         tick();
         chk("nostale_valid", 64'(out_valid), 64'd0);
         chk("nostale_out", 64'(out), 64'd0);
      end
      drive(1'b1, 16'hABCD, 16'h1111);
      tick();
      flush_to_output();
      chk("postrst_out", 64'(out), 64'hBCDE);
      chk("postrst_valid", 64'(out_valid), 64'd1);

      // Random streams interleaved with short resets
      for (int n = 0; n < 1000; n++) begin
         rst = ($urandom_range(49) == 0);
         drive(($urandom_range(4) != 0), W'($urandom), W'($urandom));
         tick();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
